conv_input_tx: RTL and testbench

CONV_INPUT_TX -- requirements
Module: conv_input_tx

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_tx_buf.sv | 45 ++++
 rtl/conv_input_tx.sv | 200 ++++++++++++++++++++
 tb/tb_conv_input_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution input stream: transmitter states and
// TUSER field layout, also used by the engine's input memory.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_W,
        SEND_B,
        SEND_X,
        DONE
    } tx_state_e;

    // TUSER = {K, new_W}
    localparam int NEW_W_BIT = 0;
    localparam int K_LSB     = 1;

    function automatic logic k_ok(input int k, input int maxk);
        return (k >= 1) && (k <= maxk);
    endfunction

endpackage

// File: rtl/conv_tx_buf.sv
// X and W word buffers as flip-flop arrays: one host write port, combinational
// reads. Contents are not reset so weights survive across frames.
module conv_tx_buf #(
    parameter int INW = 18,
    parameter int XN  = 64,
    parameter int WN  = 25,
    parameter int AW  = 6,
    localparam int XAW = (XN > 1) ? $clog2(XN) : 1,
    localparam int WAW = (WN > 1) ? $clog2(WN) : 1
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic           wr_sel,
    input  logic [AW-1:0]  wr_addr,
    input  logic [INW-1:0] wr_data,
    input  logic [XAW-1:0] x_raddr,
    input  logic [WAW-1:0] w_raddr,
    output logic [INW-1:0] x_rdata,
    output logic [INW-1:0] w_rdata
);

    logic [INW-1:0] x_mem [XN];
    logic [INW-1:0] w_mem [WN];

    // Per-word decode compares the full address, so out-of-range writes hit nothing.
    for (genvar i = 0; i < XN; i++) begin : g_x
        always_ff @(posedge clk)
            if (wr_en && !wr_sel && 32'(wr_addr) == i)
                x_mem[i] <= wr_data;
    end

    for (genvar i = 0; i < WN; i++) begin : g_w
        always_ff @(posedge clk)
            if (wr_en && wr_sel && 32'(wr_addr) == i)
                w_mem[i] <= wr_data;
    end

    always_comb begin
        x_rdata = '0;
        w_rdata = '0;
        if (32'(x_raddr) < XN) x_rdata = x_mem[x_raddr];
        if (32'(w_raddr) < WN) w_rdata = w_mem[w_raddr];
    end

endmodule

// File: rtl/conv_input_tx.sv
// Convolution engine input stream transmitter: [W*K*K, B] then X, row-major.
// Optional CONV_TX_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module conv_input_tx
    import conv_pkg::*;
#(
    parameter int INW  = 18,
    parameter int R    = 8,
    parameter int C    = 8,
    parameter int MAXK = 5,
    localparam int K_BITS = $clog2(MAXK + 1),
    localparam int AW     = $clog2(R * C)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [INW-1:0]    wr_data,
    output logic              wr_ready,
    input  logic [K_BITS-1:0] cfg_k,
    input  logic [INW-1:0]    cfg_b,
    input  logic              cfg_new_w,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [INW-1:0]    OUTPUT_TDATA,
    output logic              OUTPUT_TVALID,
    output logic [K_BITS:0]   OUTPUT_TUSER,
    input  logic              OUTPUT_TREADY
`ifdef CONV_TX_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int NX   = R * C;
    localparam int NW   = MAXK * MAXK;
    localparam int NMAX = (NX > NW) ? NX : NW;
    localparam int IW   = $clog2(NMAX + 1);
    localparam int XAW  = (NX > 1) ? $clog2(NX) : 1;
    localparam int WAW  = (NW > 1) ? $clog2(NW) : 1;

    tx_state_e state, nxt_state;
    logic [IW-1:0]     idx, nxt_idx;
    logic [K_BITS-1:0] k_q, k_cur;
    logic [INW-1:0]    b_q;
    logic              new_w_q;
    logic [INW-1:0]    tdata_q, nxt_tdata;
    logic [K_BITS:0]   tuser_q, nxt_tuser;
    logic              tvalid_q, nxt_tvalid;
    logic              done_q, err_q;
    logic              xfer, start_ok, start_bad, load;
    logic [IW-1:0]     kk_last;
    logic [INW-1:0]    x_rdata, w_rdata;

    assign wr_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign xfer      = tvalid_q && OUTPUT_TREADY;
    assign start_ok  = (state == IDLE) && start && k_ok(int'(cfg_k), MAXK);
    assign start_bad = (state == IDLE) && start && !k_ok(int'(cfg_k), MAXK);
    assign kk_last   = IW'(k_q) * IW'(k_q) - IW'(1);
    // On the start cycle the config is not captured yet, so use it directly.
    assign k_cur     = (state == IDLE) ? cfg_k : k_q;

    conv_tx_buf #(
        .INW (INW),
        .XN  (NX),
        .WN  (NW),
        .AW  (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en && wr_ready),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .x_raddr (nxt_idx[XAW-1:0]),
        .w_raddr (nxt_idx[WAW-1:0]),
        .x_rdata (x_rdata),
        .w_rdata (w_rdata)
    );

    // Next state and index describe the beat to be held in the output register.
    always_comb begin
        nxt_state  = state;
        nxt_idx    = idx;
        nxt_tvalid = tvalid_q;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    nxt_state  = cfg_new_w ? SEND_W : SEND_X;
                    nxt_idx    = '0;
                    nxt_tvalid = 1'b1;
                    load       = 1'b1;
                end
            end
            SEND_W: begin
                if (xfer) begin
                    load = 1'b1;
                    if (idx == kk_last) begin
                        nxt_state = SEND_B;
                        nxt_idx   = '0;
                    end else begin
                        nxt_idx = idx + IW'(1);
                    end
                end
            end
            SEND_B: begin
                if (xfer) begin
                    load      = 1'b1;
                    nxt_state = SEND_X;
                    nxt_idx   = '0;
                end
            end
            SEND_X: begin
                if (xfer) begin
                    if (idx == IW'(NX - 1)) begin
                        nxt_state  = DONE;
                        nxt_tvalid = 1'b0;
                    end else begin
                        nxt_idx = idx + IW'(1);
                        load    = 1'b1;
                    end
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_tdata = '0;
        nxt_tuser = '0;
        case (nxt_state)
            SEND_W: begin
                nxt_tdata                    = w_rdata;
                nxt_tuser[NEW_W_BIT]         = 1'b1;
                nxt_tuser[K_LSB +: K_BITS]   = k_cur;
            end
            SEND_B: begin
                nxt_tdata                    = b_q;
                nxt_tuser[NEW_W_BIT]         = 1'b1;
                nxt_tuser[K_LSB +: K_BITS]   = k_cur;
            end
            SEND_X:  nxt_tdata = x_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            k_q      <= '0;
            b_q      <= '0;
            new_w_q  <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            tvalid_q <= nxt_tvalid;
            done_q   <= (state == DONE);
            err_q    <= start_bad;
            if (start_ok) begin
                k_q     <= cfg_k;
                b_q     <= cfg_b;
                new_w_q <= cfg_new_w;
            end
            if (load) begin
                tdata_q <= nxt_tdata;
                tuser_q <= nxt_tuser;
            end
        end
    end

    assign done          = done_q;
    assign err           = err_q;
    assign OUTPUT_TDATA  = tdata_q;
    assign OUTPUT_TUSER  = tuser_q;
    assign OUTPUT_TVALID = tvalid_q;

`ifdef CONV_TX_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= '0;
        else if (done_q)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

    // Frame kind is implied by the state path; kept for engine-side debug taps.
    logic unused_new_w;
    assign unused_new_w = new_w_q;

endmodule

// File: tb/tb_conv_input_tx.sv
// Directed bench for conv_input_tx: full frames, weight reuse, stalls, bad K,
// mid-frame reset and (with CONV_TX_FRAME_CNT_EN) the frame counter.
module tb_conv_input_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en, wr_sel;
    logic [5:0]  wr_addr;
    logic [17:0] wr_data;
    logic        wr_ready;
    logic [2:0]  cfg_k;
    logic [17:0] cfg_b;
    logic        cfg_new_w, start;
    logic        busy, done, err;
    logic [17:0] tdata;
    logic        tvalid;
    logic [3:0]  tuser;
    logic        tready;
`ifdef CONV_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int nchk = 0;
    int nerr = 0;
    int fc_exp = 0;
    logic [17:0] x_mdl [64];
    logic [17:0] w_mdl [25];

    always #5 clk = ~clk;

    conv_input_tx dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .cfg_k         (cfg_k),
        .cfg_b         (cfg_b),
        .cfg_new_w     (cfg_new_w),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .OUTPUT_TDATA  (tdata),
        .OUTPUT_TVALID (tvalid),
        .OUTPUT_TUSER  (tuser),
        .OUTPUT_TREADY (tready)
`ifdef CONV_TX_FRAME_CNT_EN
        ,
        .frame_cnt     (frame_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input bit sel, input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr[5:0];
        wr_data = data[17:0];
    endtask

    function automatic void exp_beat(input int n, input int k, input int b, input bit new_w,
                                     output logic [17:0] d, output logic [3:0] u);
        int nk;
        nk = k * k;
        if (new_w && n < nk) begin
            d = w_mdl[n];
            u = 4'(2 * k + 1);
        end else if (new_w && n == nk) begin
            d = b[17:0];
            u = 4'(2 * k + 1);
        end else begin
            d = x_mdl[new_w ? n - nk - 1 : n];
            u = 4'd0;
        end
    endfunction

    // One frame: drives TREADY per cycle, scores every beat and every stall.
    task automatic run_frame(input int k, input int b, input bit new_w, input bit rnd,
                             input bit poke, input int abort_at);
        int ntot, n, cyc;
        bit stall;
        logic [17:0] pd, ed;
        logic [3:0]  pu, eu;
        ntot  = (new_w ? k * k + 1 : 0) + 64;
        n     = 0;
        stall = 1'b0;
        pd    = '0;
        pu    = '0;
        @(negedge clk);
        cfg_k     = 3'(k);
        cfg_b     = b[17:0];
        cfg_new_w = new_w;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 600) begin
            if (done) break;
            if (poke && cyc == 10) begin
                chk("busy_mid", busy, 1);
                chk("wr_ready_busy", wr_ready, 0);
                start = 1'b1; cfg_k = 3'd2; cfg_b = 18'd5; cfg_new_w = 1'b0;
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 18'd999;
            end
            if (poke && cyc == 11) begin
                chk("err_busy_start", err, 0);
                start = 1'b0;
                wr_en = 1'b0;
            end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                chk("stall_data", tdata, pd);
                chk("stall_user", tuser, pu);
            end
            if (tvalid && tready) begin
                exp_beat(n, k, b, new_w, ed, eu);
                chk($sformatf("beat%0d_data", n), tdata, ed);
                chk($sformatf("beat%0d_user", n), tuser, eu);
                n++;
                if (abort_at > 0 && n == abort_at) return;
            end
            stall = tvalid && !tready;
            pd    = tdata;
            pu    = tuser;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("beats", n, ntot);
        if (!rnd) chk("done_cyc", cyc, ntot + 2);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_end", busy, 0);
        tready = 1'b1;
        fc_exp++;
    endtask

    task automatic bad_start(input int k);
        @(negedge clk);
        cfg_k = 3'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("err_k%0d", k), err, 1);
        chk("err_tvalid", tvalid, 0);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_pulse", err, 0);
        chk("err_tvalid2", tvalid, 0);
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        cfg_k = 3'd3; cfg_b = '0; cfg_new_w = 1'b0; start = 1'b0; tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tuser", tuser, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1);

        for (int i = 0; i < 64; i++) begin x_mdl[i] = 18'(i); wr(1'b0, i, i); end
        for (int i = 0; i < 25; i++) begin
            w_mdl[i] = (i < 9) ? 18'(i + 1) : 18'(100 + i);
            wr(1'b1, i, int'(w_mdl[i]));
        end
        wr(1'b1, 32, 555);
        @(negedge clk);
        wr_en = 1'b0;

        run_frame(3, -7, 1'b1, 1'b0, 1'b0, 0);
        run_frame(3, -7, 1'b0, 1'b0, 1'b0, 0);
        bad_start(0);
        bad_start(6);
        run_frame(5, 12345, 1'b1, 1'b1, 1'b0, 0);
        run_frame(3, 77, 1'b1, 1'b0, 1'b1, 0);
`ifdef CONV_TX_FRAME_CNT_EN
        chk("frame_cnt_4", frame_cnt, 32'(fc_exp));
`endif

        run_frame(3, -7, 1'b1, 1'b0, 1'b0, 20);
        reset_n = 1'b0;
        #1;
        chk("abort_tvalid", tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tdata", tdata, 0);
        fc_exp = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end

        run_frame(3, -7, 1'b1, 1'b0, 1'b0, 0);
        run_frame(3, -7, 1'b0, 1'b0, 1'b0, 0);
        run_frame(1, 42, 1'b1, 1'b0, 1'b0, 0);
`ifdef CONV_TX_FRAME_CNT_EN
        chk("frame_cnt_3", frame_cnt, 32'(fc_exp));
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
